// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART.
// Holds the register map, CON bit positions, FSM state encodings and the baud divisor.
package uart_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0;
  localparam logic [31:0] OFF_RXD = 32'h4;
  localparam logic [31:0] OFF_CON = 32'h8;

  localparam int CON_RXV    = 0;
  localparam int CON_OVR    = 1;
  localparam int CON_FERR   = 2;
  localparam int CON_TXDONE = 3;
  localparam int CON_TXBUSY = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, start-edge detect, mid-bit sampling.
// Emits one-cycle rx_done / rx_ferr pulses; rx_byte holds the last shifted byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       in,
  output logic       rx_done,
  output logic       rx_ferr,
  output logic [7:0] rx_byte
);

  localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  logic        s1, s2, s3;
  rx_state_e   st, st_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bitn, bitn_nxt;
  logic [7:0]  sh, sh_nxt;
  logic        done_nxt, ferr_nxt;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      // Synchroniser starts at the idle-line level so reset release never looks like a start edge.
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      st      <= RX_IDLE;
      cnt     <= '0;
      bitn    <= '0;
      sh      <= '0;
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      s1      <= in;
      s2      <= s1;
      s3      <= s2;
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      bitn    <= bitn_nxt;
      sh      <= sh_nxt;
      rx_done <= done_nxt;
      rx_ferr <= ferr_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = (cnt == FULL_M1) ? 16'd0 : cnt + 16'd1;
    bitn_nxt = bitn;
    sh_nxt   = sh;
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
    case (st)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (s3 && !s2) st_nxt = RX_START;
      end
      RX_START: if (cnt == HALF_M1) begin
        cnt_nxt  = '0;
        bitn_nxt = '0;
        st_nxt   = s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == FULL_M1) begin
        sh_nxt   = {s2, sh[7:1]};
        bitn_nxt = bitn + 3'd1;
        if (bitn == 3'd7) st_nxt = RX_STOP;
      end
      RX_STOP: if (cnt == FULL_M1) begin
        st_nxt   = RX_IDLE;
        done_nxt = s2;
        ferr_nxt = !s2;
      end
      default: st_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = sh;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the MEM stage: TXD/RXD/CON decode, TX FSM, status flags.
// rdata is zero unless addressed, so it can be OR-combined with other read sources.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int          CLK_HZ = 50_000_000,
  parameter int          BAUD   = 9600,
  parameter logic [31:0] BASE   = 32'h4000_0018
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        out,
  input  logic        in
);

  localparam int          DIV    = calc_div(CLK_HZ, BAUD);
  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [31:0] A_TXD  = BASE + OFF_TXD;
  localparam logic [31:0] A_RXD  = BASE + OFF_RXD;
  localparam logic [31:0] A_CON  = BASE + OFF_CON;

  logic       hit_txd, hit_rxd, hit_con;
  logic       wr_acc, rd_rxd, rd_con;
  logic [7:0] txd, rxd;
  logic       rx_valid, overrun, frame_err, tx_done, tx_busy;
  logic [4:0] con;
  logic       rx_done, rx_ferr;
  logic [7:0] rx_byte;
  logic       unused_bits;

  assign hit_txd     = (addr[31:2] == A_TXD[31:2]);
  assign hit_rxd     = (addr[31:2] == A_RXD[31:2]);
  assign hit_con     = (addr[31:2] == A_CON[31:2]);
  assign wr_acc      = wr && hit_txd && !tx_busy;
  assign rd_rxd      = rd && hit_rxd;
  assign rd_con      = rd && hit_con;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  uart_rx #(.DIV(DIV)) u_rx (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .in      (in),
    .rx_done (rx_done),
    .rx_ferr (rx_ferr),
    .rx_byte (rx_byte)
  );

  // TX: the accepting write only sets tx_busy; the FSM leaves IDLE one edge later,
  // so the start bit appears at k+1 and tx_busy drops as the stop bit ends.
  tx_state_e   tx_st, tx_nxt;
  logic [15:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]  tx_bit, tx_bit_nxt;
  logic [7:0]  tx_sh, tx_sh_nxt;
  logic        out_nxt, tx_fin;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      out    <= 1'b1;
    end else begin
      tx_st  <= tx_nxt;
      tx_cnt <= tx_cnt_nxt;
      tx_bit <= tx_bit_nxt;
      tx_sh  <= tx_sh_nxt;
      out    <= out_nxt;
    end
  end

  always_comb begin
    tx_nxt     = tx_st;
    tx_cnt_nxt = (tx_cnt == DIV_M1) ? 16'd0 : tx_cnt + 16'd1;
    tx_bit_nxt = tx_bit;
    tx_sh_nxt  = tx_sh;
    tx_fin     = 1'b0;
    case (tx_st)
      TX_IDLE: begin
        tx_cnt_nxt = '0;
        if (tx_busy) begin
          tx_nxt    = TX_START;
          tx_sh_nxt = txd;
        end
      end
      TX_START: if (tx_cnt == DIV_M1) begin
        tx_nxt     = TX_DATA;
        tx_bit_nxt = '0;
      end
      TX_DATA: if (tx_cnt == DIV_M1) begin
        tx_bit_nxt = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_nxt = TX_STOP;
        else                tx_sh_nxt = tx_sh >> 1;
      end
      TX_STOP: if (tx_cnt == DIV_M1) begin
        tx_nxt = TX_IDLE;
        tx_fin = 1'b1;
      end
      default: tx_nxt = TX_IDLE;
    endcase
    case (tx_nxt)
      TX_START: out_nxt = 1'b0;
      TX_DATA:  out_nxt = tx_sh_nxt[0];
      default:  out_nxt = 1'b1;
    endcase
  end

  // Flag updates: a set in the same cycle as a read-clear wins.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      txd       <= '0;
      rxd       <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      if (wr_acc)  txd <= wdata[7:0];
      if (rx_done) rxd <= rx_byte;

      if (rx_done)     rx_valid <= 1'b1;
      else if (rd_rxd) rx_valid <= 1'b0;

      if (rx_done && rx_valid) overrun <= 1'b1;
      else if (rd_rxd)         overrun <= 1'b0;

      if (rx_ferr)     frame_err <= 1'b1;
      else if (rd_con) frame_err <= 1'b0;

      if (wr_acc)      tx_busy <= 1'b1;
      else if (tx_fin) tx_busy <= 1'b0;

      if (tx_fin)                tx_done <= 1'b1;
      else if (wr_acc || rd_con) tx_done <= 1'b0;
    end
  end

  always_comb begin
    con             = '0;
    con[CON_RXV]    = rx_valid;
    con[CON_OVR]    = overrun;
    con[CON_FERR]   = frame_err;
    con[CON_TXDONE] = tx_done;
    con[CON_TXBUSY] = tx_busy;
  end

  always_comb begin
    rdata = '0;
    if (Reset_n && rd) begin
      if (hit_txd)      rdata = {24'd0, txd};
      else if (hit_rxd) rdata = {24'd0, rxd};
      else if (hit_con) rdata = {27'd0, con};
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at DIV=10: reset state, TX framing, RX flags, reset mid-frame.
module tb_uart_mmio;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        rd     = 1'b0;
  logic        wr     = 1'b0;
  logic        ser_in = 1'b1;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [31:0] rdata;
  logic        ser_out;
  int          vecs   = 0;
  int          errs   = 0;

  uart_mmio #(.CLK_HZ(1000), .BAUD(100), .BASE(32'h4000_0018)) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .out     (ser_out),
    .in      (ser_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    rd   = 1'b1;
    #1;
    chk(tag, rdata, exp);
    cyc();
    rd   = 1'b0;
    addr = '0;
  endtask

  task automatic wr_txd(input logic [7:0] b);
    addr  = TXD;
    wdata = {24'd0, b};
    wr    = 1'b1;
    cyc();
    wr    = 1'b0;
    addr  = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      ser_in = fr[j];
      repeat (10) cyc();
    end
    ser_in = 1'b1;
  endtask

  // Called right after the accepting write edge k; checks every cycle of the frame.
  task automatic tx_check(input logic [7:0] b, input bit extras);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 100; i++) begin
      cyc();
      rd = 1'b0;
      wr = 1'b0;
      chk("tx_line", 32'(ser_out), 32'(fr[i / 10]));
      if (extras) begin
        if (i == 30) begin addr = TXD; wdata = 32'h3C; wr = 1'b1; end
        if (i == 50) begin addr = CON; rd = 1'b1; #1; chk("con_busy", rdata, 32'h10); end
        if (i == 60) begin addr = TXD; rd = 1'b1; #1; chk("txd_kept", rdata, 32'hA5); end
        if (i == 99) begin addr = CON; rd = 1'b1; #1; chk("con_last", rdata, 32'h10); end
      end
    end
    cyc();
    rd   = 1'b0;
    addr = '0;
    chk("tx_idle", 32'(ser_out), 32'd1);
    rd_chk(CON, 32'h08, "con_done");
    rd_chk(CON, 32'h00, "con_clr");
  endtask

  initial begin
    // reset state
    rd   = 1'b1;
    addr = TXD;
    repeat (3) cyc();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_out", 32'(ser_out), 32'd1);
    rd    = 1'b0;
    rst_n = 1'b1;
    cyc();
    rd_chk(CON, 32'h0, "rst_con");
    rd_chk(RXD, 32'h0, "rst_rxd");
    rd_chk(TXD, 32'h0, "rst_txd");
    rd_chk(32'h4000_0000, 32'h0, "miss");

    // TX frame with a dropped mid-frame write
    wr_txd(8'hA5);
    tx_check(8'hA5, 1'b1);
    rd_chk(TXD, 32'hA5, "txd_after");

    // RX good byte, then overrun
    send_byte(8'h5A, 1'b1);
    rd_chk(CON, 32'h01, "rx_con");
    rd_chk(RXD, 32'h5A, "rx_data");
    rd_chk(CON, 32'h00, "rx_clr");
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rd_chk(CON, 32'h03, "ovr_con");
    rd_chk(RXD + 32'd3, 32'h22, "ovr_data");
    rd_chk(CON, 32'h00, "ovr_clr");

    // false start, then framing error
    ser_in = 1'b0;
    repeat (3) cyc();
    ser_in = 1'b1;
    repeat (30) cyc();
    rd_chk(CON, 32'h00, "glitch_con");
    send_byte(8'h77, 1'b0);
    rd_chk(CON, 32'h04, "ferr_con");
    rd_chk(RXD, 32'h22, "ferr_rxd");
    rd_chk(CON, 32'h00, "ferr_clr");

    // reset in the middle of a TX frame
    wr_txd(8'hC3);
    repeat (35) cyc();
    chk("pre_rst_line", 32'(ser_out), 32'd0);
    rst_n = 1'b0;
    rd    = 1'b1;
    addr  = CON;
    cyc();
    chk("rst_line", 32'(ser_out), 32'd1);
    chk("rst_rd_con", rdata, 32'h0);
    rst_n = 1'b1;
    rd    = 1'b0;
    cyc();
    rd_chk(CON, 32'h0, "post_rst_con");
    wr_txd(8'h81);
    tx_check(8'h81, 1'b0);

    // read and write to TXD in the same cycle
    addr  = TXD;
    wdata = 32'h5E;
    wr    = 1'b1;
    rd    = 1'b1;
    #1;
    chk("rdwr_old", rdata, 32'h81);
    cyc();
    wr = 1'b0;
    rd = 1'b0;
    rd_chk(TXD, 32'h5E, "rdwr_new");
    repeat (105) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
